// File: rtl/servo_pkg.sv
// servo_pkg: shared FSM encoding, constants and saturation helper for the servo UART transmitter
package servo_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam int DATA_BITS = 8;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;
  localparam int DEF_CLK_DIV = 5208;
  function automatic logic [15:0] sat16(input logic signed [63:0] v);
    return v > 64'(SAT_MAX) ? SAT_MAX : v < 64'(SAT_MIN) ? SAT_MIN : v[15:0];
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with synchronous clear and a one-cycle terminal-count tick
module uart_baud_gen
  import servo_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clk_G,
  input  logic Rst_G,
  input  logic clr,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == 16'(CLK_DIV - 1);
  // free-running bit timer, restarted when a word is accepted
  always_ff @(posedge Clk_G or posedge Rst_G)
    if (Rst_G) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/servo_uart_tx.sv
// servo_uart_tx: saturates a signed word to 16 bits and sends it as two 8N1 bytes, high first (TX_PARITY_EN adds even parity)
module servo_uart_tx
  import servo_pkg::*;
#(
  parameter int cant_bits = 13,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic                        Clk_G,
  input  logic                        Rst_G,
  input  logic signed [2*cant_bits-1:0] Dato,
  input  logic                        Tx_Start,
  output logic                        Tx,
  output logic                        Tx_Busy,
  output logic                        Tx_Done
);
`ifdef TX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif
  logic [2:0]  state, nxt, bit_cnt, idx;
  logic [15:0] sh;
  logic [7:0]  cur;
  logic        byte_lo, tick, accept, tx_d;
  assign accept = Tx_Start && !Tx_Busy;
  assign cur    = byte_lo ? sh[7:0] : sh[15:8];
  assign idx    = state == ST_DATA ? bit_cnt + {2'b00, tick} : 3'd0;
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .Clk_G(Clk_G),
    .Rst_G(Rst_G),
    .clr  (accept),
    .tick (tick)
  );
  // state register
  always_ff @(posedge Clk_G or posedge Rst_G)
    if (Rst_G) state <= ST_IDLE;
    else state <= nxt;
  // next-state logic: every transition after IDLE waits for a bit tick
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:   nxt = accept ? ST_START : ST_IDLE;
      ST_START:  nxt = tick ? ST_DATA : ST_START;
      ST_DATA:   nxt = tick && bit_cnt == 3'(DATA_BITS - 1) ? AFTER_DATA : ST_DATA;
`ifdef TX_PARITY_EN
      ST_PARITY: nxt = tick ? ST_STOP : ST_PARITY;
`endif
      ST_STOP:   nxt = !tick ? ST_STOP : byte_lo ? ST_IDLE : ST_START;
      default:   nxt = ST_IDLE;
    endcase
  end
  // line level for the state being entered, so Tx changes on the same edge as the state
  always_comb begin
    tx_d = 1'b1;
    case (nxt)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = cur[idx];
`ifdef TX_PARITY_EN
      ST_PARITY: tx_d = ^cur;
`endif
      default:   tx_d = 1'b1;
    endcase
  end
  // latched word, bit/byte counters and registered outputs
  always_ff @(posedge Clk_G or posedge Rst_G)
    if (Rst_G) begin
      sh      <= '0;
      bit_cnt <= '0;
      byte_lo <= 1'b0;
      Tx      <= 1'b1;
      Tx_Busy <= 1'b0;
      Tx_Done <= 1'b0;
    end else begin
      sh      <= accept ? sat16(64'(Dato)) : sh;
      bit_cnt <= state == ST_DATA && tick ? bit_cnt + 3'd1 : bit_cnt;
      byte_lo <= accept ? 1'b0 : state == ST_STOP && tick ? !byte_lo : byte_lo;
      Tx      <= tx_d;
      Tx_Busy <= nxt != ST_IDLE;
      Tx_Done <= state == ST_STOP && tick && byte_lo;
    end
endmodule
